// File: rtl/xnor_pkg.sv
// Shared constants and helpers for the XNOR pattern correlator.
// The match counter is built only when XNOR_CORR_COUNT_EN is defined.
package xnor_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 8;

    // Bits needed to hold a count in the range 0..w.
    function automatic int sw_bits(input int w);
        return $clog2(w + 1);
    endfunction

    // Increment v, holding at the all-ones value of a w-bit counter.
    function automatic logic [63:0] sat_inc(input logic [63:0] v, input int w);
        logic [63:0] lim;
        lim = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return (v >= lim) ? lim : v + 64'd1;
    endfunction

endpackage

// File: rtl/xnor_popcount.sv
// Combinational population count of a WIDTH-bit agreement vector.
// Used by xnor_correlator (XNOR_CORR_COUNT_EN has no effect here).
module xnor_popcount
    import xnor_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    localparam int SW = sw_bits(WIDTH)
) (
    input  logic [WIDTH-1:0] bits,
    output logic [SW-1:0]    count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            count = count + SW'(bits[i]);
        end
    end

endmodule

// File: rtl/xnor_correlator.sv
// Streaming XNOR correlator: serial window vs. pattern, score, match pulse.
// Define XNOR_CORR_COUNT_EN to build the saturating match counter.
module xnor_correlator
    import xnor_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W,
    localparam int SW = sw_bits(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             din_valid,
    input  logic             din,
    input  logic [WIDTH-1:0] pattern,
    input  logic [SW-1:0]    threshold,
    output logic [SW-1:0]    score,
    output logic             score_valid,
    output logic             match,
    output logic [CNT_W-1:0] match_count
);

    // din_valid is a plain qualifier with no backpressure: every edge with
    // din_valid=1 and clear=0 accepts din; score_valid/match are one-cycle
    // pulses the consumer must take on the cycle they appear.
    logic [WIDTH-1:0] sr;
    logic [SW-1:0]    fill;
    logic             s1_valid;
    logic [WIDTH-1:0] agree;
    logic [SW-1:0]    pc;
    logic             hit;

    assign agree = ~(sr ^ pattern);
    assign hit   = s1_valid && (pc >= threshold);

    xnor_popcount #(.WIDTH(WIDTH)) u_popcount (
        .bits  (agree),
        .count (pc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr          <= '0;
            fill        <= '0;
            s1_valid    <= 1'b0;
            score       <= '0;
            score_valid <= 1'b0;
            match       <= 1'b0;
        end else if (clear) begin
            // score deliberately keeps its last value across a flush
            sr          <= '0;
            fill        <= '0;
            s1_valid    <= 1'b0;
            score_valid <= 1'b0;
            match       <= 1'b0;
        end else begin
            if (din_valid) begin
                sr <= {sr[WIDTH-2:0], din};
                if (fill != SW'(WIDTH)) fill <= fill + 1'b1;
            end
            s1_valid    <= din_valid && (fill >= SW'(WIDTH - 1));
            score_valid <= s1_valid;
            match       <= hit;
            if (s1_valid) score <= pc;
        end
    end

`ifdef XNOR_CORR_COUNT_EN
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (hit) begin
            count_q <= CNT_W'(sat_inc(64'(count_q), CNT_W));
        end
    end

    assign match_count = count_q;
`else
    assign match_count = '0;
`endif

endmodule

// File: tb/tb_xnor_correlator.sv
// Directed self-checking bench for xnor_correlator (WIDTH=8, CNT_W=2).
// Expected match_count follows whether XNOR_CORR_COUNT_EN is defined.
module tb_xnor_correlator;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear;
    logic       din_valid;
    logic       din;
    logic [7:0] pattern;
    logic [3:0] threshold;
    logic [3:0] score;
    logic       score_valid;
    logic       match;
    logic [1:0] match_count;

    int checks = 0;
    int errors = 0;
    int sv_pulses = 0;
    int m_pulses = 0;

`ifdef XNOR_CORR_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    xnor_correlator #(.WIDTH(8), .CNT_W(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .din_valid   (din_valid),
        .din         (din),
        .pattern     (pattern),
        .threshold   (threshold),
        .score       (score),
        .score_valid (score_valid),
        .match       (match),
        .match_count (match_count)
    );

    always #5 clk = ~clk;

    // pulse monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (score_valid) sv_pulses++;
        if (match) m_pulses++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        din = b;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
    endtask

    // oldest bit first, so w ends up as the window with w[0] newest
    task automatic send_bits(input logic [7:0] w, input int n, input int gap);
        for (int i = 7; i > 7 - n; i--) begin
            send_bit(w[i]);
            if (i > 8 - n) repeat (gap) tick();
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        din_valid = 1'b0;
        tick();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        checks++; if (score !== 4'd0) begin errors++; $display("FAIL reset_score got %0d want 0", score); end
        checks++; if (score_valid !== 1'b0) begin errors++; $display("FAIL reset_sv got %b want 0", score_valid); end
        checks++; if (match !== 1'b0) begin errors++; $display("FAIL reset_match got %b want 0", match); end
        checks++; if (match_count !== 2'd0) begin errors++; $display("FAIL reset_count got %0d want 0", match_count); end
        tick();
        tick();
        #2 rst = 1'b0;
        tick();
    endtask

    task automatic test_exact();
        do_clear();
        pattern = 8'hA5;
        threshold = 4'd8;
        send_bits(8'hA5, 8, 0);
        checks++; if (score_valid !== 1'b0) begin errors++; $display("FAIL exact_early_sv got %b want 0", score_valid); end
        tick();
        checks++; if (score !== 4'd8) begin errors++; $display("FAIL exact_score got %0d want 8", score); end
        checks++; if (score_valid !== 1'b1) begin errors++; $display("FAIL exact_sv got %b want 1", score_valid); end
        checks++; if (match !== 1'b1) begin errors++; $display("FAIL exact_match got %b want 1", match); end
        checks++; if (match_count !== (CNT_EN ? 2'd1 : 2'd0)) begin errors++; $display("FAIL exact_count got %0d want %0d", match_count, CNT_EN ? 1 : 0); end
        tick();
        checks++; if (match !== 1'b0) begin errors++; $display("FAIL exact_match_drop got %b want 0", match); end
        checks++; if (score !== 4'd8) begin errors++; $display("FAIL exact_score_hold got %0d want 8", score); end
    endtask

    task automatic test_over_threshold();
        do_clear();
        threshold = 4'd9;
        send_bits(8'hA5, 8, 0);
        tick();
        checks++; if (score_valid !== 1'b1) begin errors++; $display("FAIL thr9_sv got %b want 1", score_valid); end
        checks++; if (match !== 1'b0) begin errors++; $display("FAIL thr9_match got %b want 0", match); end
    endtask

    task automatic test_partial();
        int sv0;
        int m0;
        do_clear();
        threshold = 4'd0;
        sv0 = sv_pulses;
        m0 = m_pulses;
        send_bits(8'hA5, 7, 0);
        repeat (5) tick();
        checks++; if (sv_pulses - sv0 !== 0) begin errors++; $display("FAIL partial_sv got %0d want 0", sv_pulses - sv0); end
        checks++; if (m_pulses - m0 !== 0) begin errors++; $display("FAIL partial_match got %0d want 0", m_pulses - m0); end
    endtask

    task automatic test_single_err();
        do_clear();
        threshold = 4'd7;
        send_bits(8'hA4, 8, 0);
        tick();
        checks++; if (score !== 4'd7) begin errors++; $display("FAIL err_t7_score got %0d want 7", score); end
        checks++; if (match !== 1'b1) begin errors++; $display("FAIL err_t7_match got %b want 1", match); end
        do_clear();
        threshold = 4'd8;
        send_bits(8'hA4, 8, 0);
        tick();
        checks++; if (score !== 4'd7) begin errors++; $display("FAIL err_t8_score got %0d want 7", score); end
        checks++; if (match !== 1'b0) begin errors++; $display("FAIL err_t8_match got %b want 0", match); end
    endtask

    task automatic test_gapped();
        int sv0;
        int m0;
        do_clear();
        threshold = 4'd8;
        sv0 = sv_pulses;
        m0 = m_pulses;
        send_bits(8'hA5, 8, 3);
        checks++; if (sv_pulses - sv0 !== 0) begin errors++; $display("FAIL gap_early got %0d want 0", sv_pulses - sv0); end
        tick();
        checks++; if (match !== 1'b1) begin errors++; $display("FAIL gap_match got %b want 1", match); end
        checks++; if (score !== 4'd8) begin errors++; $display("FAIL gap_score got %0d want 8", score); end
        repeat (3) tick();
        checks++; if (m_pulses - m0 !== 1) begin errors++; $display("FAIL gap_pulses got %0d want 1", m_pulses - m0); end
    endtask

    task automatic test_clear();
        int sv0;
        do_clear();
        threshold = 4'd8;
        send_bits(8'hFF, 5, 0);
        clear = 1'b1;
        din = 1'b1;
        din_valid = 1'b1;
        tick();
        clear = 1'b0;
        din_valid = 1'b0;
        checks++; if (match_count !== 2'd0) begin errors++; $display("FAIL clr_count got %0d want 0", match_count); end
        sv0 = sv_pulses;
        send_bits(8'hA5, 7, 0);
        repeat (3) tick();
        checks++; if (sv_pulses - sv0 !== 0) begin errors++; $display("FAIL clr_refill got %0d want 0", sv_pulses - sv0); end
        send_bit(1'b1);
        tick();
        checks++; if (score_valid !== 1'b1) begin errors++; $display("FAIL clr_sv got %b want 1", score_valid); end
        checks++; if (match !== 1'b1) begin errors++; $display("FAIL clr_match got %b want 1", match); end
    endtask

    task automatic test_async_reset();
        int sv0;
        do_clear();
        threshold = 4'd8;
        send_bits(8'hA5, 8, 0);
        tick();
        #2 rst = 1'b1;
        #1;
        checks++; if (match !== 1'b0) begin errors++; $display("FAIL arst_match got %b want 0", match); end
        checks++; if (score_valid !== 1'b0) begin errors++; $display("FAIL arst_sv got %b want 0", score_valid); end
        checks++; if (score !== 4'd0) begin errors++; $display("FAIL arst_score got %0d want 0", score); end
        checks++; if (match_count !== 2'd0) begin errors++; $display("FAIL arst_count got %0d want 0", match_count); end
        #1 rst = 1'b0;
        sv0 = sv_pulses;
        send_bits(8'hA5, 7, 0);
        repeat (3) tick();
        checks++; if (sv_pulses - sv0 !== 0) begin errors++; $display("FAIL arst_refill got %0d want 0", sv_pulses - sv0); end
    endtask

    task automatic test_saturation();
        int m0;
        int exp_c;
        logic exp_m;
        do_clear();
        threshold = 4'd0;
        m0 = m_pulses;
        for (int i = 1; i <= 14; i++) begin
            din = i[0];
            din_valid = (i <= 13);
            tick();
            exp_m = (i >= 9);
            exp_c = (!CNT_EN || i < 9) ? 0 : ((i - 8 > 3) ? 3 : i - 8);
            checks++; if (match !== exp_m) begin errors++; $display("FAIL sat_match[%0d] got %b want %b", i, match, exp_m); end
            checks++; if (match_count !== 2'(exp_c)) begin errors++; $display("FAIL sat_count[%0d] got %0d want %0d", i, match_count, exp_c); end
        end
        din_valid = 1'b0;
        tick();
        checks++; if (m_pulses - m0 !== 6) begin errors++; $display("FAIL sat_pulses got %0d want 6", m_pulses - m0); end
    endtask

    initial begin
        rst = 1'b1;
        clear = 1'b0;
        din_valid = 1'b0;
        din = 1'b0;
        pattern = 8'hA5;
        threshold = 4'd8;
        test_reset();
        test_exact();
        test_over_threshold();
        test_partial();
        test_single_err();
        test_gapped();
        test_clear();
        test_async_reset();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/xnor_correlator.md
# xnor_correlator

Parametrised streaming bit-pattern correlator built on bitwise XNOR. A serial bit stream is shifted into a WIDTH-bit window. Each window is XNORed against a programmable pattern, and the agreeing bits are counted to give a similarity score. A one-cycle match pulse fires when the score reaches a threshold. It is the sequential successor to the single-gate XNOR primitive and serves as the sync-word / preamble detector in front of the serial receive path.

## Interface
Parameters:
- WIDTH, 8: pattern and window length in bits (≥2).
- CNT_W, 8: width of the match counter.
- SW: localparam, $clog2(WIDTH+1). Width of the score and the threshold.

Ports:
- clk  input  1  sole clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous flush of the window, pipeline and counter.
- din_valid  input  1  din is sampled on this edge.
- din  input  1  serial data bit.
- pattern  input  WIDTH  reference word; pattern[0] aligns with the newest bit.
- threshold  input  SW  minimum score for a match.
- score  output  SW  number of agreeing bits for the last scored window.
- score_valid  output  1  one-cycle pulse; score updated.
- match  output  1  one-cycle pulse; score ≥ threshold.
- match_count  output  CNT_W  saturating count of match pulses.

## Operation
- Window: on an edge with din_valid=1, sr <= {sr[WIDTH-2:0], din}. sr[0] is the newest bit. With din_valid=0 the window holds.
- Fill: the fill counter increments per accepted bit and saturates at WIDTH. A window is scoreable only once WIDTH bits have been accepted since the last reset or clear.
- Stage 1, the shift edge: s1_valid <= din_valid && (fill ≥ WIDTH-1). This means the window is full after this shift.
- Stage 2, the next edge:
  - score_valid <= s1_valid.
  - If s1_valid: score <= popcount(~(sr ^ pattern)).
  - match <= s1_valid && (popcount ≥ threshold).
  - Otherwise score holds its last value.
- Arithmetic: popcount is unsigned, range 0..WIDTH, and fits SW bits. The threshold comparison is unsigned.
  - threshold=0 matches every scored window.
  - threshold>WIDTH never matches.
- pattern and threshold are used combinationally at the stage-2 edge. A change affects only windows scored at that edge or later.
- Overlapping detections are allowed. Each accepted bit after fill yields one independent score.
- match_count: increments on every match pulse and saturates at 2^CNT_W-1, with no wrap.
- clear=1 has priority over din_valid on the same edge. It zeroes sr, fill, s1_valid, score_valid, match and match_count. score holds its value. The bit presented with clear is discarded.

## Timing
- Reset: sr=0, fill=0, s1_valid=0, score=0, score_valid=0, match=0, match_count=0.
- Reset mid-stream aborts any in-flight window. Outputs go to zero immediately, with no edge required.
- Latency: a bit accepted at edge N, which completes a window, gives score, score_valid and match visible after edge N+1.
- Throughput: one score per clock with continuous din_valid.
- match and score_valid are never asserted for more than one cycle per accepted bit.
- match_count reflects a match on the same edge that raises match.

## Configuration
- XNOR_CORR_COUNT_EN defined: the match counter is built as specified.
- XNOR_CORR_COUNT_EN undefined: the counter is omitted, and match_count is tied to 0 with the port kept. All other behaviour is unchanged.

## Structure
- Package xnor_pkg holds:
  - the default WIDTH and CNT_W constants;
  - the clog2-based SW helper function;
  - the saturating-increment function.
- One sub-module, xnor_popcount: parametrised WIDTH, combinational, takes the XNOR vector and returns an SW-bit count. It is instanced once, between sr/pattern and the stage-2 registers.

## Test plan
- Exact match:
  - Stimulus: WIDTH=8, pattern=8'hA5, threshold=8. Feed 1,0,1,0,0,1,0,1 on consecutive edges.
  - Response: one edge after the 8th bit, score=8, score_valid=1, match=1 for one cycle, match_count=1.
- Partial fill: seven valid bits only, followed by idle cycles -> score_valid and match stay 0.
- Single-bit error:
  - Stimulus: pattern 8'hA5, stream yielding sr=8'hA4.
  - threshold=7 -> score=7, match=1.
  - threshold=8 -> score=7, match=0.
- Gapped valid:
  - Stimulus: the 8'hA5 sequence with din_valid low for 3 cycles between each bit.
  - Response: the same single match, one edge after the last valid bit, and no pulses during the gaps.
- Clear and reset:
  - clear asserted together with a valid bit after 5 bits -> that bit is discarded and the window empty.
  - The next 8 valid bits are required before any score_valid.
  - rst pulsed asynchronously mid-window -> all outputs drop to 0 without a clock edge.
- Saturation:
  - Stimulus: CNT_W=2, threshold=0, 8 fill bits followed by 5 more bits.
  - Response: 6 match pulses, with match_count sequencing 1,2,3,3,3,3.
  - With XNOR_CORR_COUNT_EN undefined, match_count stays 0.
